// File: rtl/csr_result_writer.sv
// Writeback end of the sparse matmul datapath: scans a latched dense NxN matrix
// in row-major order and emits CSR value/column pairs and row pointers to two BRAM write ports.
module csr_result_writer #(
  parameter int N         = 3,
  parameter int W         = 8,
  parameter int COLW      = 2,
  parameter int AW        = 4,
  parameter int BASE_ADDR = 1,
  parameter int NNZW      = 4,
  parameter int PW        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*N*W-1:0]     result_flat,
  output logic                 busy,
  output logic                 done,
  output logic [NNZW-1:0]      nnz,
  output logic                 val_we,
  output logic [AW-1:0]        val_addr,
  output logic [COLW+W-1:0]    val_din,
  output logic                 ptr_we,
  output logic [PW-1:0]        ptr_addr,
  output logic [NNZW-1:0]      ptr_din
);

  localparam int KW = (N * N > 1) ? $clog2(N * N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_PFIN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [N*N*W-1:0]   mat_q, mat_d;
  logic [COLW-1:0]    r_q, r_d, c_q, c_d;
  logic [NNZW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [NNZW-1:0]    nnz_q, nnz_d;
  logic               val_we_q, val_we_d;
  logic [AW-1:0]      val_addr_q, val_addr_d;
  logic [COLW+W-1:0]  val_din_q, val_din_d;
  logic               ptr_we_q, ptr_we_d;
  logic [PW-1:0]      ptr_addr_q, ptr_addr_d;
  logic [NNZW-1:0]    ptr_din_q, ptr_din_d;

  logic [W-1:0]       elem_arr [N*N];
  logic [KW-1:0]      k_s;
  logic [W-1:0]       elem_s;

  for (genvar g = 0; g < N * N; g++) begin : g_unpack
    assign elem_arr[g] = mat_q[g*W +: W];
  end

  assign k_s    = KW'(r_q) * KW'(N) + KW'(c_q);
  assign elem_s = elem_arr[k_s];

  // Next-state and registered-output computation; strobes default low every cycle.
  always_comb begin
    state_d    = state_q;
    mat_d      = mat_q;
    r_d        = r_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    nnz_d      = nnz_q;
    val_we_d   = 1'b0;
    val_addr_d = val_addr_q;
    val_din_d  = val_din_q;
    ptr_we_d   = 1'b0;
    ptr_addr_d = ptr_addr_q;
    ptr_din_d  = ptr_din_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mat_d   = result_flat;
          r_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        // Row pointer is the count before this row's first element is counted.
        if (c_q == '0) begin
          ptr_we_d   = 1'b1;
          ptr_addr_d = PW'(r_q);
          ptr_din_d  = cnt_q;
        end else begin
          ptr_we_d   = 1'b0;
        end
        if (|elem_s) begin
          val_we_d   = 1'b1;
          val_addr_d = AW'(BASE_ADDR) + AW'(cnt_q);
          val_din_d  = {c_q, elem_s};
          cnt_d      = cnt_q + NNZW'(1);
        end else begin
          val_we_d   = 1'b0;
        end
        if (c_q == COLW'(N - 1)) begin
          c_d = '0;
          if (r_q == COLW'(N - 1)) begin
            state_d = S_PFIN;
          end else begin
            r_d = r_q + COLW'(1);
          end
        end else begin
          c_d = c_q + COLW'(1);
        end
      end
      S_PFIN: begin
        ptr_we_d   = 1'b1;
        ptr_addr_d = PW'(N);
        ptr_din_d  = cnt_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        nnz_d   = cnt_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mat_q      <= '0;
      r_q        <= '0;
      c_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nnz_q      <= '0;
      val_we_q   <= 1'b0;
      val_addr_q <= '0;
      val_din_q  <= '0;
      ptr_we_q   <= 1'b0;
      ptr_addr_q <= '0;
      ptr_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      mat_q      <= mat_d;
      r_q        <= r_d;
      c_q        <= c_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nnz_q      <= nnz_d;
      val_we_q   <= val_we_d;
      val_addr_q <= val_addr_d;
      val_din_q  <= val_din_d;
      ptr_we_q   <= ptr_we_d;
      ptr_addr_q <= ptr_addr_d;
      ptr_din_q  <= ptr_din_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign nnz      = nnz_q;
  assign val_we   = val_we_q;
  assign val_addr = val_addr_q;
  assign val_din  = val_din_q;
  assign ptr_we   = ptr_we_q;
  assign ptr_addr = ptr_addr_q;
  assign ptr_din  = ptr_din_q;

endmodule

// File: doc/csr_result_writer.md
Name: csr_result_writer

Overview:
Writeback end of the sparse matmul datapath: takes the dense NxN product matrix produced by the Gustavson row engine and writes it out in CSR form into two block-RAM write ports, one for the value/column pairs and one for the row pointers. The block is the writer counterpart to the block-RAM readers that load A and B. A start pulse latches the whole matrix, a scan FSM visits one element per clock, and done/nnz report completion.

Parameters:
N, 3, matrix dimension (NxN)
W, 8, element width in bits
COLW, 2, column index width, ceil(log2(N)) with a minimum of 1
AW, 4, value-memory address width
BASE_ADDR, 1, first value-memory address written (value memories are 1-based)
NNZW, 4, width of nnz count and row pointers, ceil(log2(N*N+1))
PW, 2, row-pointer address width, ceil(log2(N+1))

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  reset
start  in  1  one-cycle request; sampled only in IDLE
result_flat  in  N*N*W  dense matrix, element (r,c) at bits [(r*N+c)*W +: W]
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
nnz  out  NNZW  nonzero count of the last completed matrix
val_we  out  1  value-memory write strobe
val_addr  out  AW  value-memory address
val_din  out  COLW+W  {col, value}
ptr_we  out  1  row-pointer write strobe
ptr_addr  out  PW  row-pointer address, 0..N
ptr_din  out  NNZW  row-pointer value

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs are 0, the FSM is in IDLE, and the internal counters r, c and cnt are 0.
- If rst is asserted mid-operation: it takes priority over everything else. Every write strobe is low from the next cycle, no further writes are issued, done does not pulse, and nnz returns to 0.
- Registered outputs: every output comes directly from a flop. There is no combinational path from an input to an output.
- State IDLE: if start=1, latch result_flat into an internal copy, clear cnt/r/c, set busy=1 and go to SCAN. Otherwise all strobes stay low.
- State SCAN: handles one element per cycle, in row-major order r=0..N-1, c=0..N-1. Element k is processed in the cycle after edge k+1, counting edge 0 as the edge that accepted start.
  - When c==0: ptr_we=1, ptr_addr=r, ptr_din=cnt, where cnt is the value before this element is counted.
  - If the element is nonzero: val_we=1, val_addr=BASE_ADDR+cnt, val_din={c[COLW-1:0], element}, and cnt increments.
  - If the element is zero: val_we=0.
  - Both ports can be written in the same cycle.
  - After the element (N-1,N-1), go to PFIN.
- Zero test: an element is nonzero if any of its W bits is set. Values are unsigned, with no sign interpretation.
- State PFIN: ptr_we=1, ptr_addr=N, ptr_din=final cnt; go to DONE.
- State DONE: done=1 for exactly one cycle, busy=0 in the same cycle, nnz is loaded with cnt; return to IDLE.
- Latency: start accepted at edge 0 gives done high in cycle N*N+2 (cycle 11 for N=3). The block accepts a new start in the cycle after done is high.
- start while busy (SCAN, PFIN or DONE) is ignored; nothing is queued.
- result_flat changes after start has no effect, because only the latched copy is used.
- Boundaries:
  - Maximum cnt is N*N. It fits NNZW and cannot wrap.
  - val_addr reaches at most BASE_ADDR+N*N-1 (9).
  - An all-zero matrix produces no val writes, all row pointers 0, and nnz=0.
- nnz holds its value until the next done or rst.

Test Plan:
- Identity, each diagonal element 0x01, start at edge 0:
  - val writes (addr, data) are (1, 0x001), (2, 0x101), (3, 0x201).
  - ptr writes are 0,1,2,3 at addrs 0..3.
  - done in cycle 11, nnz=3.
- Sparse matrix, rows [0,5,0], [0,0,0], [7,0,9]:
  - val writes (addr, data) are (1, 0x105), (2, 0x007), (3, 0x209).
  - rowptr is 0,1,1,3; nnz=3.
- All zeros:
  - no val_we pulses.
  - ptr writes are 0,0,0,0; nnz=0; done in cycle 11.
- Dense matrix with every element 0xFF:
  - 9 val writes at addrs 1..9, cols cycling 0,1,2.
  - rowptr is 0,3,6,9; nnz=9.
  - element 0x80 is also treated as nonzero.
- start re-pulsed during SCAN and result_flat changed mid-scan:
  - output is identical to the undisturbed run.
  - exactly one done pulse.
- rst asserted in cycle 5 of SCAN:
  - from cycle 6: no further strobes, busy=0, nnz=0, no done pulse.
  - a following start completes normally.
